// File: rtl/bus_trace_pkg.sv
// Shared types and encodings for the bus_trace capture block.
package bus_trace_pkg;

  localparam int unsigned TRACE_ADDR_W   = 16;
  localparam int unsigned TRACE_DATA_W   = 8;
  localparam int unsigned TRACE_STATUS_W = 8;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_ARMED_ENC = 2'd1;
  localparam logic [1:0] ST_POST_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ARMED = ST_ARMED_ENC,
    ST_POST  = ST_POST_ENC,
    ST_DONE  = ST_DONE_ENC
  } trace_state_t;

  // Layout of one stored sample at the default bus widths.
  typedef struct packed {
    logic                      wr;
    logic [TRACE_DATA_W-1:0]   data;
    logic [TRACE_ADDR_W-1:0]   address;
    logic [TRACE_STATUS_W-1:0] status;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port
// whose output can be forced to zero for out-of-range reads.
module trace_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic                     rd_zero,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write: a slot being overwritten this cycle returns its old sample.
  always_ff @(posedge clk) begin
    if (reset)        rd_data <= '0;
    else if (rd_zero) rd_data <= '0;
    else              rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bus_trace.sv
// Circular bus trace for the 6502 core with masked address trigger.
// Optional BUS_TRACE_WRITE_TRIG_EN adds trig_wr_only (trigger on writes only).
module bus_trace
  import bus_trace_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned POST_TRIG  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bus_valid,
  input  logic [ADDR_WIDTH-1:0]    address,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_enable,
  input  logic [TRACE_STATUS_W-1:0] status,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic [ADDR_WIDTH-1:0]    trig_addr,
  input  logic [ADDR_WIDTH-1:0]    trig_mask,
`ifdef BUS_TRACE_WRITE_TRIG_EN
  input  logic                     trig_wr_only,
`endif
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   entry_count,
  output logic                     wrapped,
  input  logic [$clog2(DEPTH)-1:0] rd_index,
  output logic [DATA_WIDTH+ADDR_WIDTH+TRACE_STATUS_W:0] rd_entry
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 1 + DATA_WIDTH + ADDR_WIDTH + TRACE_STATUS_W;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bus_trace: DEPTH must be a power of two and at least 4");
  end
  if (POST_TRIG >= DEPTH) begin : g_bad_post
    $error("bus_trace: POST_TRIG must be less than DEPTH");
  end

  trace_state_t    state_q, state_d;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   post_cnt;
  logic            match_c;
  logic            store_c;
  logic            clear_c;
  logic            post_clr_c;
  logic            post_inc_c;
  logic [EW-1:0]   wr_entry_c;
  logic [AW-1:0]   rd_addr_c;
  logic            rd_zero_c;

`ifdef BUS_TRACE_WRITE_TRIG_EN
  assign match_c = bus_valid && (((address ^ trig_addr) & trig_mask) == '0)
                   && (!trig_wr_only || wr_enable);
`else
  assign match_c = bus_valid && (((address ^ trig_addr) & trig_mask) == '0);
`endif

  assign wr_entry_c = {wr_enable, (wr_enable ? wr_data : rd_data), address, status};

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus capture controls; disarm takes priority over everything else.
  always_comb begin
    state_d    = state_q;
    store_c    = 1'b0;
    clear_c    = 1'b0;
    post_clr_c = 1'b0;
    post_inc_c = 1'b0;
    if (disarm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d = ST_ARMED;
            clear_c = 1'b1;
          end
        end
        ST_ARMED: begin
          if (bus_valid) begin
            store_c = 1'b1;
            if (match_c) begin
              post_clr_c = 1'b1;
              state_d    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (bus_valid) begin
            store_c    = 1'b1;
            post_inc_c = 1'b1;
            if (AW'(post_cnt + 1'b1) == AW'(POST_TRIG)) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_c) begin
      wr_ptr      <= '0;
      entry_count <= '0;
      wrapped     <= 1'b0;
      post_cnt    <= '0;
    end else begin
      if (store_c) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (entry_count == CW'(DEPTH)) wrapped <= 1'b1;
        else                           entry_count <= entry_count + 1'b1;
      end
      if (post_clr_c)      post_cnt <= '0;
      else if (post_inc_c) post_cnt <= post_cnt + 1'b1;
    end
  end

  // Oldest entry sits entry_count slots behind the write pointer.
  assign rd_addr_c = wr_ptr - entry_count[AW-1:0] + rd_index;
  assign rd_zero_c = ({1'b0, rd_index} >= entry_count);

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (store_c && !reset),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry_c),
    .rd_addr (rd_addr_c),
    .rd_zero (rd_zero_c),
    .rd_data (rd_entry)
  );

  assign state = state_q;

endmodule

// File: doc/bus_trace.md
# bus_trace

Parametrised single-clock bus trace capture for the 6502 processor core. It samples the processor bus (address, read/write data, write enable, status register P) into a circular buffer. A masked address trigger, with optional write qualification, freezes the buffer a programmable number of samples after the trigger. The stored history is then read out oldest-first, for simulation and on-chip debug beside `proc` and `memory_block`.

## Interface
- `ADDR_WIDTH`, 16, bus address width
- `DATA_WIDTH`, 8, bus data width
- `DEPTH`, 64, buffer entries; power of two, ≥4
- `POST_TRIG`, 16, samples stored after the trigger sample; 0 ≤ POST_TRIG < DEPTH, enforced at elaboration
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `bus_valid`  in  1  one-cycle strobe per processor bus cycle; only strobed cycles are sampled
- `address`  in  ADDR_WIDTH  processor address
- `rd_data`  in  DATA_WIDTH  memory read data
- `wr_data`  in  DATA_WIDTH  processor write data
- `wr_enable`  in  1  processor write strobe
- `status`  in  8  processor P register
- `arm`  in  1  pulse: clear and start capture
- `disarm`  in  1  pulse: abort to IDLE
- `trig_addr`  in  ADDR_WIDTH  trigger address
- `trig_mask`  in  ADDR_WIDTH  1 = bit compared
- `state`  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
- `entry_count`  out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
- `wrapped`  out  1  buffer overwritten at least once since arm
- `rd_index`  in  $clog2(DEPTH)  readout index, 0 = oldest
- `rd_entry`  out  1+DATA_WIDTH+ADDR_WIDTH+8  {wr, data, address, status}

## Operation
- Entry: wr = `wr_enable`; data = `wr_enable ? wr_data : rd_data`; address; status.
- Match: `bus_valid && ((address ^ trig_addr) & trig_mask) == 0`. A zero mask matches every valid cycle.
- IDLE: no capture. `arm` → ARMED, with write pointer, entry_count and wrapped cleared.
- ARMED: each `bus_valid` stores an entry at the write pointer and increments the pointer modulo DEPTH.
  - entry_count increments, saturating at DEPTH.
  - wrapped sets on the first store made while entry_count == DEPTH.
  - A matching sample is stored. Then the block goes → POST, or → DONE if POST_TRIG == 0.
- POST: stores `bus_valid` samples with a post counter. The sample that makes the count equal POST_TRIG → DONE. Further matches are ignored.
- DONE: no capture; buffer frozen. `arm` re-arms exactly as from IDLE.
- `arm` in ARMED or POST is ignored. `disarm` in any state → IDLE; contents are kept, counts are held.
- `arm` and `disarm` in the same cycle: `disarm` wins.
- Readout in any state: physical index = (wr_ptr − entry_count + rd_index) mod DEPTH. If rd_index ≥ entry_count, rd_entry = 0.

## Timing
- Reset outputs: state=IDLE, entry_count=0, wrapped=0, rd_entry=0. Post counter and pointers are 0. RAM contents are not cleared.
- Reset mid-capture takes effect in the next cycle and overrides `arm` and `bus_valid` in the same cycle.
- Sample in cycle n: visible in entry_count in n+1 and readable from n+1.
- State changes are registered; a trigger in cycle n shows `state` = POST/DONE in n+1.
- Read latency is 1 cycle: rd_entry in n+1 reflects rd_index, count and pointer of cycle n.
- `bus_valid` may be high every cycle; there is no back-pressure.

## Configuration
- `BUS_TRACE_WRITE_TRIG_EN` defined: adds input `trig_wr_only` (1 bit). When 1, match additionally requires `wr_enable == 1`.
- Not defined: the port is absent and match ignores `wr_enable`.

## Structure
- `bus_trace_pkg` holds:
  - the `trace_state_t` enum (IDLE/ARMED/POST/DONE);
  - a `trace_entry_t` packed struct built from localparam widths;
  - state encoding constants.
- Sub-module `trace_ram`: simple dual-port, DEPTH×entry width, one write port, one registered read port. bus_trace supplies the write enable, pointer and read address.

## Test plan
- DEPTH=8, POST_TRIG=2, mask=16'hFFFF, trig_addr=16'h0203. Arm, then strobe reads at 16'h0200..16'h0206. Required: DONE after the 16'h0205 sample, entry_count=6, rd_index 0..5 returns 16'h0200..16'h0205, rd_index 6 returns 0.
- Same setup with 20 samples from 16'h1000 before a trigger at 16'h1014. Required: wrapped=1, entry_count=8, oldest entry = 16'h100F, index 5 = 16'h1014.
- POST_TRIG=0, mask=16'h0000. Arm, one valid read. Required: DONE next cycle, entry_count=1.
- Write at 16'h4000, wr_data=8'hA5, rd_data=8'h3C, status=8'h81. Required: entry {1, 8'hA5, 16'h4000, 8'h81}. With macro and trig_wr_only=1, a read at the trigger address does not trigger; a write does.
- `arm`+`disarm` together in ARMED: state=IDLE. Assert `reset` mid-POST: state=IDLE, entry_count=0 next cycle.
- Re-arm from DONE: entry_count=0, wrapped=0, capture restarts.
